// File: rtl/gen3_scrambler_lane_if.sv
// Byte-stream handshake bundle between the block framer, the scrambler lane and the serializer.
// Latency: none (wires only).
// Backpressure: carries valid/ready pairs; the lane stalls the input side while the output is held.
//
// Port summary (direction given from the scrambler lane's point of view):
//   in_valid_i / in_ready_o / in_data_i / in_sof_i / in_sync_hdr_i : upstream byte channel
//   out_valid_o / out_ready_i / out_data_o / out_sof_o / out_sync_hdr_o : downstream byte channel
//   modport slave  : the scrambler lane
//   modport master : the environment driving the lane (framer on the input side, serializer on the output side)
interface gen3_scrambler_lane_if;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [7:0] in_data_i;
    logic       in_sof_i;
    logic [1:0] in_sync_hdr_i;

    logic       out_valid_o;
    logic       out_ready_i;
    logic [7:0] out_data_o;
    logic       out_sof_o;
    logic [1:0] out_sync_hdr_o;

    modport slave (
        input  in_valid_i,
        output in_ready_o,
        input  in_data_i,
        input  in_sof_i,
        input  in_sync_hdr_i,
        output out_valid_o,
        input  out_ready_i,
        output out_data_o,
        output out_sof_o,
        output out_sync_hdr_o
    );

    modport master (
        output in_valid_i,
        input  in_ready_o,
        output in_data_i,
        output in_sof_i,
        output in_sync_hdr_i,
        input  out_valid_o,
        output out_ready_i,
        input  out_data_o,
        input  out_sof_o,
        input  out_sync_hdr_o
    );
endinterface

// File: rtl/gen3_scrambler_lane.sv
// Per-lane 128b/130b transmit scrambler: block framing, per-byte scramble/bypass/hold/re-seed of a 23-bit LFSR.
// Latency: 1 cycle from input accept to out_valid_o (one-deep registered output stage).
// Backpressure: in_ready_o = ~out_valid_o | out_ready_i; a held output stalls the input and freezes the LFSR.
//
// Ports:
//   clk_i, rst_i         : clock (rising edge) and asynchronous active-high reset
//   lfsr_seed_i          : lane seed, loaded into the LFSR at the end of every EIEOS block
//   scramble_enable_i    : 0 = bypass every byte and hold the LFSR (framing is still tracked)
//   bus (slave modport)  : input byte channel (valid/ready/data/sof/sync header) and output byte channel
//   lfsr_state_o         : current LFSR register
//   err_framing_o        : one-cycle pulse on a framing error
//
// Build option: define GEN3_SCR_FRAMING_CHK_EN to enable framing-error detection and err_framing_o.
// Without it, err_framing_o is 0, in_sof_i always restarts a block silently, and sync headers 00/11 are
// handled like an ordered-set header (01).
module gen3_scrambler_lane #(
    parameter logic [22:0] RST_SEED = 23'h1DBFBC
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [22:0]           lfsr_seed_i,
    input  logic                  scramble_enable_i,
    gen3_scrambler_lane_if.slave  bus,
    output logic [22:0]           lfsr_state_o,
    output logic                  err_framing_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DATA  = 3'd1,
        S_OS    = 3'd2,
        S_SKP   = 3'd3,
        S_EIEOS = 3'd4
    } state_t;

    // Galois feedback mask for x^23+x^21+x^16+x^8+x^5+x^2+1 (terms below x^23).
    localparam logic [22:0] LFSR_TAPS = 23'h210125;
    localparam logic [1:0]  HDR_DATA  = 2'b10;
    localparam logic [7:0]  SYM_SKP   = 8'hAA;
    localparam logic [7:0]  SYM_EIEOS = 8'h00;
    localparam logic [3:0]  LAST_IDX  = 4'd15;

    // ------------------------------------------------------------------
    // LFSR helpers: eight serial Galois steps per byte. The keystream bit
    // for step i is the register MSB before that step, LSB first.
    // ------------------------------------------------------------------
    function automatic logic [22:0] lfsr_adv8(input logic [22:0] s);
        logic [22:0] v;
        v = s;
        for (int i = 0; i < 8; i++) begin
            v = {v[21:0], 1'b0} ^ (v[22] ? LFSR_TAPS : 23'h0);
        end
        return v;
    endfunction

    function automatic logic [7:0] lfsr_ks8(input logic [22:0] s);
        logic [22:0] v;
        logic [7:0]  k;
        v = s;
        k = 8'h00;
        for (int i = 0; i < 8; i++) begin
            k[i] = v[22];
            v    = {v[21:0], 1'b0} ^ (v[22] ? LFSR_TAPS : 23'h0);
        end
        return k;
    endfunction

    // ------------------------------------------------------------------
    // Registers and combinational nets
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [22:0] r_lfsr;
    logic        r_out_vld;
    logic [7:0]  r_out_dat;
    logic        r_out_sof;
    logic [1:0]  r_out_hdr;
    logic        r_err;

    state_t      w_state_nxt;
    logic [3:0]  w_cnt_nxt;
    logic [22:0] w_lfsr_nxt;
    logic [22:0] w_lfsr_upd;
    logic [7:0]  w_out_dat;
    state_t      w_dec_state;
    state_t      w_byte_state;
    logic [3:0]  w_byte_idx;
    logic        w_in_rdy;
    logic        w_accept;
    logic        w_err_event;
`ifdef GEN3_SCR_FRAMING_CHK_EN
    logic        w_hdr_bad;
`endif

    assign w_in_rdy = ~r_out_vld | bus.out_ready_i;
    assign w_accept = bus.in_valid_i & w_in_rdy;

    // ------------------------------------------------------------------
    // Block-type decode of a symbol-0 byte from its sync header and first
    // symbol. Only meaningful when in_sof_i is set.
    // ------------------------------------------------------------------
    always_comb begin
        w_dec_state = S_OS;
`ifdef GEN3_SCR_FRAMING_CHK_EN
        w_hdr_bad   = 1'b0;
`endif
        if (bus.in_sync_hdr_i == HDR_DATA) begin
            w_dec_state = S_DATA;
        end else begin
            if (bus.in_data_i == SYM_SKP) begin
                w_dec_state = S_SKP;
            end else if (bus.in_data_i == SYM_EIEOS) begin
                w_dec_state = S_EIEOS;
            end else begin
                w_dec_state = S_OS;
            end
`ifdef GEN3_SCR_FRAMING_CHK_EN
            // 00/11 are not legal headers: the byte is passed through and
            // the lane waits in IDLE for the next symbol 0.
            if (bus.in_sync_hdr_i != 2'b01) begin
                w_dec_state = S_IDLE;
                w_hdr_bad   = 1'b1;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Framing errors: symbol 0 arriving mid-block, a non-symbol-0 byte
    // while waiting for a block, or an illegal sync header.
    // ------------------------------------------------------------------
`ifdef GEN3_SCR_FRAMING_CHK_EN
    assign w_err_event = w_accept & (
                             (bus.in_sof_i & (r_cnt != 4'd0)) |
                             (~bus.in_sof_i & (r_state == S_IDLE)) |
                             (bus.in_sof_i & w_hdr_bad));
`else
    assign w_err_event = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state / per-byte action. A symbol-0 byte is handled with the
    // freshly decoded block type at index 0, so back-to-back blocks and
    // mid-block restarts need no idle cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_lfsr_nxt   = r_lfsr;
        w_lfsr_upd   = r_lfsr;
        w_out_dat    = bus.in_data_i;
        w_byte_state = r_state;
        w_byte_idx   = r_cnt;

        if (bus.in_sof_i) begin
            w_byte_state = w_dec_state;
            w_byte_idx   = 4'd0;
        end

        // Keystream comes from the pre-advance LFSR state.
        if (scramble_enable_i) begin
            unique case (w_byte_state)
                S_DATA: begin
                    w_out_dat  = bus.in_data_i ^ lfsr_ks8(r_lfsr);
                    w_lfsr_upd = lfsr_adv8(r_lfsr);
                end
                S_OS: begin
                    w_lfsr_upd = lfsr_adv8(r_lfsr);
                end
                S_EIEOS: begin
                    if (w_byte_idx == LAST_IDX) begin
                        w_lfsr_upd = lfsr_seed_i;
                    end
                end
                default: begin
                    w_lfsr_upd = r_lfsr;
                end
            endcase
        end

        if (w_accept) begin
            w_lfsr_nxt = w_lfsr_upd;
            if (w_byte_state == S_IDLE) begin
                // Unframed byte: passed through, counter parked at 0.
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end else if (w_byte_idx == LAST_IDX) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end else begin
                w_state_nxt = w_byte_state;
                w_cnt_nxt   = w_byte_idx + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Framing state, byte counter and LFSR registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_lfsr  <= RST_SEED;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lfsr  <= w_lfsr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // One-deep output stage. Data/sof/header only load on accept, so a
    // stalled output holds steady until the consumer takes it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out_vld <= 1'b0;
            r_out_dat <= 8'h00;
            r_out_sof <= 1'b0;
            r_out_hdr <= 2'b00;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_err_event;
            if (w_accept) begin
                r_out_vld <= 1'b1;
                r_out_dat <= w_out_dat;
                r_out_sof <= bus.in_sof_i;
                // The header register keeps the current block's header for all its bytes.
                if (bus.in_sof_i) begin
                    r_out_hdr <= bus.in_sync_hdr_i;
                end
            end else if (bus.out_ready_i) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    assign bus.in_ready_o     = w_in_rdy;
    assign bus.out_valid_o    = r_out_vld;
    assign bus.out_data_o     = r_out_dat;
    assign bus.out_sof_o      = r_out_sof;
    assign bus.out_sync_hdr_o = r_out_hdr;
    assign lfsr_state_o       = r_lfsr;
    assign err_framing_o      = r_err;

endmodule

// File: tb/tb_gen3_scrambler_lane.sv
`timescale 1ns/1ps
module tb_gen3_scrambler_lane;

    localparam logic [22:0] RST_SEED = 23'h1DBFBC;
    localparam logic [22:0] EI_SEED  = 23'h0F0F0F;
`ifdef GEN3_SCR_FRAMING_CHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    typedef enum logic [2:0] {K_DATA, K_OS, K_SKP, K_EIEOS, K_PASS} kind_t;

    logic        clk;
    logic        rst;
    logic [22:0] lfsr_seed;
    logic        scr_en;
    logic [22:0] lfsr_state;
    logic        err_framing;

    gen3_scrambler_lane_if bus();

    gen3_scrambler_lane #(.RST_SEED(RST_SEED)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .lfsr_seed_i       (lfsr_seed),
        .scramble_enable_i (scr_en),
        .bus               (bus),
        .lfsr_state_o      (lfsr_state),
        .err_framing_o     (err_framing)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [22:0] mdl;       // reference LFSR, as a polynomial residue
    logic [22:0] mdl_save;
    logic [7:0]  d, e, last_e;

    // Multiply the state polynomial by x^n modulo P(x) = x^23+x^21+x^16+x^8+x^5+x^2+1.
    function automatic logic [22:0] mul_x(input logic [22:0] s, input int n);
        logic [23:0] p;
        p = {1'b0, s};
        for (int i = 0; i < n; i++) begin
            p = p << 1;
            if (p[23]) p = p ^ 24'hA10125;
        end
        return p[22:0];
    endfunction

    // Keystream bit i is the top coefficient of s * x^i.
    function automatic logic [7:0] ks(input logic [22:0] s);
        logic [7:0]  k;
        logic [22:0] t;
        for (int i = 0; i < 8; i++) begin
            t    = mul_x(s, i);
            k[i] = t[22];
        end
        return k;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected output byte and model update for one accepted byte.
    task automatic model(input kind_t k, input int idx, input logic [7:0] din, input logic en,
                         output logic [7:0] dout);
        dout = din;
        if (en) begin
            case (k)
                K_DATA:  begin dout = din ^ ks(mdl); mdl = mul_x(mdl, 8); end
                K_OS:    mdl = mul_x(mdl, 8);
                K_EIEOS: if (idx == 15) mdl = lfsr_seed;
                default: ;
            endcase
        end
    endtask

    task automatic send_byte(input string tag, input logic [7:0] din, input logic sof,
                             input logic [1:0] hdr, input logic [7:0] exp_d, input logic exp_err);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.in_valid_i    = 1'b1;
        bus.in_data_i     = din;
        bus.in_sof_i      = sof;
        bus.in_sync_hdr_i = hdr;
        while (bus.in_ready_o !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "/in_ready"}, 32'(bus.in_ready_o), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        check({tag, "/out_valid"}, 32'(bus.out_valid_o), 32'd1);
        check({tag, "/out_data"}, 32'(bus.out_data_o), 32'(exp_d));
        check({tag, "/out_sof"}, 32'(bus.out_sof_o), 32'(sof));
        if (sof) check({tag, "/out_hdr"}, 32'(bus.out_sync_hdr_o), 32'(hdr));
        check({tag, "/lfsr"}, 32'(lfsr_state), 32'(mdl));
        check({tag, "/err"}, 32'(err_framing), 32'(exp_err));
    endtask

    task automatic send_block(input string tag, input kind_t k, input logic [1:0] hdr,
                              input logic [7:0] b0, input logic [7:0] fill, input bit rnd);
        logic [7:0] bd, be;
        for (int i = 0; i < 16; i++) begin
            bd = (i == 0) ? b0 : (rnd ? 8'($urandom) : fill);
            model(k, i, bd, scr_en, be);
            send_byte(tag, bd, i == 0, hdr, be, 1'b0);
        end
    endtask

    initial begin
        rst               = 1'b1;
        scr_en            = 1'b1;
        lfsr_seed         = EI_SEED;
        bus.in_valid_i    = 1'b0;
        bus.in_data_i     = 8'h00;
        bus.in_sof_i      = 1'b0;
        bus.in_sync_hdr_i = 2'b00;
        bus.out_ready_i   = 1'b1;
        mdl               = RST_SEED;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst/out_valid", 32'(bus.out_valid_o), 32'd0);
        check("rst/out_data", 32'(bus.out_data_o), 32'd0);
        check("rst/out_sof", 32'(bus.out_sof_o), 32'd0);
        check("rst/out_hdr", 32'(bus.out_sync_hdr_o), 32'd0);
        check("rst/err", 32'(err_framing), 32'd0);
        check("rst/lfsr", 32'(lfsr_state), 32'(RST_SEED));
        rst = 1'b0;
        @(negedge clk);
        check("rst/in_ready", 32'(bus.in_ready_o), 32'd1);

        // Data block of zeros exposes the raw keystream
        send_block("zero_data", K_DATA, 2'b10, 8'h00, 8'h00, 1'b0);
        check("zero_data/lfsr128", 32'(lfsr_state), 32'(mul_x(RST_SEED, 128)));

        // EIEOS re-seeds at its last byte
        send_block("eieos", K_EIEOS, 2'b01, 8'h00, 8'hFF, 1'b0);
        check("eieos/seed", 32'(lfsr_state), 32'(EI_SEED));

        // Data, SKP, data: keystream continues across the SKP
        send_block("data_a", K_DATA, 2'b10, 8'($urandom), 8'h00, 1'b1);
        mdl_save = mdl;
        send_block("skp", K_SKP, 2'b01, 8'hAA, 8'h00, 1'b1);
        check("skp/hold", 32'(lfsr_state), 32'(mdl_save));
        send_block("data_b", K_DATA, 2'b10, 8'($urandom), 8'h00, 1'b1);

        // Ordered set: bypass, LFSR advances
        send_block("os", K_OS, 2'b01, 8'h1E, 8'h00, 1'b1);

        // Backpressure mid-block
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            model(K_DATA, i, d, 1'b1, e);
            send_byte("bp_pre", d, i == 0, 2'b10, e, 1'b0);
            last_e = e;
        end
        bus.out_ready_i = 1'b0;
        d = 8'($urandom);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) begin
                bus.in_valid_i = 1'b1;
                bus.in_data_i  = d;
                bus.in_sof_i   = 1'b0;
            end
            check("bp/in_ready", 32'(bus.in_ready_o), 32'd0);
            check("bp/out_valid", 32'(bus.out_valid_o), 32'd1);
            check("bp/out_data", 32'(bus.out_data_o), 32'(last_e));
            check("bp/lfsr", 32'(lfsr_state), 32'(mdl));
        end
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("bp/drained", 32'(bus.out_valid_o), 32'd0);
        for (int i = 6; i < 16; i++) begin
            if (i != 6) d = 8'($urandom);
            model(K_DATA, i, d, 1'b1, e);
            send_byte("bp_post", d, 1'b0, 2'b10, e, 1'b0);
        end

        // Symbol 0 arriving at byte 5 restarts the block
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            model(K_DATA, i, d, 1'b1, e);
            send_byte("restart_pre", d, i == 0, 2'b10, e, 1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            model(K_DATA, i, d, 1'b1, e);
            send_byte("restart", d, i == 0, 2'b10, e, (i == 0) ? ERR_EXP : 1'b0);
        end

        // Unframed byte while waiting for a block
        model(K_PASS, 0, 8'h3C, 1'b1, e);
        send_byte("unframed", 8'h3C, 1'b0, 2'b10, e, ERR_EXP);

        // Illegal sync header
`ifdef GEN3_SCR_FRAMING_CHK_EN
        model(K_PASS, 0, 8'h55, 1'b1, e);
        send_byte("bad_hdr", 8'h55, 1'b1, 2'b11, e, 1'b1);
`else
        send_block("bad_hdr", K_OS, 2'b11, 8'h55, 8'h00, 1'b1);
`endif

        // Scrambling disabled: pure bypass, LFSR frozen
        scr_en   = 1'b0;
        mdl_save = mdl;
        send_block("disabled", K_DATA, 2'b10, 8'h5A, 8'h5A, 1'b0);
        check("disabled/lfsr", 32'(lfsr_state), 32'(mdl_save));
        scr_en = 1'b1;

        // Reset in the middle of a block
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            model(K_DATA, i, d, 1'b1, e);
            send_byte("mid_rst_pre", d, i == 0, 2'b10, e, 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst/lfsr", 32'(lfsr_state), 32'(RST_SEED));
        check("mid_rst/out_valid", 32'(bus.out_valid_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mdl = RST_SEED;
        send_block("after_rst", K_DATA, 2'b10, 8'($urandom), 8'h00, 1'b1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gen3_scrambler_lane.md
# gen3_scrambler_lane

Per-lane Gen3 (128b/130b) transmit scrambler stage. Owns the 23-bit LFSR state register, tracks 16-byte block framing from the sync header, and decides per byte whether to scramble, bypass, hold, or re-seed the LFSR. It sits directly downstream of the block framer and upstream of the lane serializer. A one-deep registered output stage provides valid/ready flow control.

## Interface
- RST_SEED, 23'h1DBFBC: LFSR value loaded by reset.
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- lfsr_seed_i  in  23  lane seed; loaded after each EIEOS block.
- scramble_enable_i  in  1  0 = bypass all bytes and hold the LFSR.
- in_valid_i  in  1  an input byte is offered.
- in_ready_o  out  1  the stage accepts the byte this cycle.
- in_data_i  in  8  input byte.
- in_sof_i  in  1  the byte is symbol 0 of a block.
- in_sync_hdr_i  in  2  2'b10 = data block, 2'b01 = ordered-set block; sampled only with in_sof_i.
- out_valid_o  out  1  output byte is valid.
- out_ready_i  in  1  downstream accepts the output byte.
- out_data_o  out  8  scrambled or bypassed byte.
- out_sof_o  out  1  out_data_o is symbol 0 of a block.
- out_sync_hdr_o  out  2  sync header of the current block; valid with out_sof_o.
- lfsr_state_o  out  23  current LFSR register.
- err_framing_o  out  1  one-cycle pulse on a framing error.

## Operation
- An input handshake (accept) is in_valid_i & in_ready_o. in_ready_o = ~out_valid_o | out_ready_i.
- Byte counter, 4 bits: increments on each accept and wraps from 15 to 0. The block ends at count 15.
- States: S_IDLE, S_DATA, S_OS, S_SKP, S_EIEOS.
- S_IDLE: waits for an accept with in_sof_i = 1.
  - Sync header 10 → S_DATA.
  - Sync header 01 → decode symbol 0: 8'hAA → S_SKP; 8'h00 → S_EIEOS; any other value → S_OS.
  - Sync header 00 or 11 → framing error; stay in S_IDLE and pass the byte through unscrambled.
- After the block's 16th byte, the state returns to S_IDLE. A byte with in_sof_i at count 0 is decoded in the same cycle, so back-to-back blocks have no gap.
- Per-byte action when scramble_enable_i = 1:
  - S_DATA: out = in ^ keystream byte; the LFSR advances 8 bits.
  - S_OS: out = in (bypass); the LFSR advances 8 bits.
  - S_SKP: out = in; the LFSR holds.
  - S_EIEOS: out = in; the LFSR holds. On the accept of byte 15, the LFSR loads lfsr_seed_i.
- When scramble_enable_i = 0: out = in and the LFSR holds in all states. Framing tracking continues.
- LFSR: Galois polynomial x^23+x^21+x^16+x^8+x^5+x^2+1, advanced 8 serial steps per accepted byte.
  - Keystream bit i (i = 0 LSB, first transmitted) is the serial output lfsr[22] taken before step i.
  - The keystream for a byte is taken from the pre-advance state.
- Framing errors pulse err_framing_o in these cases:
  - in_sof_i = 1 at count ≠ 0. The block restarts: the counter is forced to 1 and the new header is decoded.
  - in_sof_i = 0 at count 0 in S_IDLE. The byte passes unscrambled and the counter stays 0.
  - Invalid sync header.

## Timing
- Latency is 1 cycle from accept to out_valid_o. out_data_o, out_sof_o and out_sync_hdr_o register on accept.
- While out_valid_o & ~out_ready_i, all outputs hold stable and in_ready_o = 0.
- lfsr_state_o reflects an update in the cycle after the accept that caused it.
- Reset values:
  - out_valid_o = 0, out_data_o = 0, out_sof_o = 0, out_sync_hdr_o = 0.
  - err_framing_o = 0, state = S_IDLE, counter = 0, lfsr_state_o = RST_SEED.
  - in_ready_o = 1 after reset.
- Reset mid-block abandons the block immediately. The next block must start with in_sof_i.
- scramble_enable_i is sampled on each accept, so toggling it mid-block affects only subsequent bytes.

## Configuration
- GEN3_SCR_FRAMING_CHK_EN defined: all framing-error detection and err_framing_o are present as described above.
- Not defined:
  - err_framing_o is tied to 0.
  - in_sof_i at any count forces a restart without an error.
  - Sync headers 00 and 11 are treated as an ordered-set block (01).

## Test plan
- Reset, scramble_enable_i = 1, one data block of 16 × 8'h00 → out_data_o equals the first 16 keystream bytes of the reference model seeded with 23'h1DBFBC, and lfsr_state_o equals the model after 128 steps.
- EIEOS block (sync 01, byte 0 = 8'h00, then 15 × 8'hFF) with lfsr_seed_i = 23'h0F0F0F → bytes pass unchanged, and lfsr_state_o = 23'h0F0F0F one cycle after the last accept.
- SKP block (byte 0 = 8'hAA) between two data blocks → SKP bytes pass unchanged, and the second data block's keystream continues exactly where the first stopped.
- Backpressure: out_ready_i held low for 3 cycles mid-block → out_data_o is stable, in_ready_o = 0, no byte is lost or duplicated, and the LFSR advances exactly once per accepted byte.
- With the macro defined, in_sof_i asserted on byte 5 of a data block → err_framing_o pulses once, and the new block is decoded from that byte. With the macro undefined → no pulse, same restart.
- scramble_enable_i = 0 for a full data block of 8'h5A → output is all 8'h5A and lfsr_state_o is unchanged.
